// File: rtl/msg_reader_pkg.sv
// msg_reader shared types: FSM state encoding and ROM width constants.
package msg_reader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PRESENT,
    FIN
  } state_t;

endpackage

// File: rtl/msg_reader.sv
// Reads a TERM-terminated message from an external sync ROM, one byte per handshake.
// Optional MSG_READER_CHECKSUM_EN adds chk, the XOR of all emitted bytes.
module msg_reader
  import msg_reader_pkg::*;
#(
  parameter int          MAX_LEN = 32,
  parameter logic [7:0]  TERM    = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef MSG_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);

  localparam logic [7:0] MAX_C = 8'(MAX_LEN);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        count, count_n;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] sum, sum_n;

  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    count_n = count;
    data_n  = out_data;
    sum_n   = sum;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_n  = base_addr;
          count_n = '0;
          sum_n   = '0;
          state_n = ADDR;
        end
      end
      ADDR: state_n = DATA;
      DATA: begin
        if (rom_data == TERM || count == MAX_C) begin
          state_n = FIN;
        end else begin
          data_n  = rom_data;
          sum_n   = sum ^ rom_data;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        // Address wraps naturally at 8 bits.
        if (out_ready) begin
          addr_n  = rom_addr + 1'b1;
          count_n = count + 1'b1;
          state_n = ADDR;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      count    <= '0;
      out_data <= '0;
      sum      <= '0;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      count    <= count_n;
      out_data <= data_n;
      sum      <= sum_n;
    end
  end

  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

`ifdef MSG_READER_CHECKSUM_EN
  assign chk = sum;
`else
  logic unused_sum;
  assign unused_sum = ^sum;
`endif

endmodule

// File: tb/tb_msg_reader.sv
// Directed bench for msg_reader with a behavioural 256x8 synchronous ROM.
// Define MSG_READER_CHECKSUM_EN to also check chk.
module tb_msg_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef MSG_READER_CHECKSUM_EN
  logic [7:0] chk;
`endif

  logic [7:0] rom [256];

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] base;
    int         stall_at;
    int         stall_len;
    bit         poke;
    int         len;
    logic [7:0] exp [32];
  } vec_t;

  vec_t vecs [6];

  msg_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef MSG_READER_CHECKSUM_EN
    ,
    .chk       (chk)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run(input vec_t v, input string tag);
    int cyc, n, stalled, last_acc, dones, done_cyc, exp_stall;
    logic [7:0] held, xs;
    bit hold_on;
    n = 0; stalled = 0; last_acc = 0; dones = 0;
    done_cyc = -1; hold_on = 0; held = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; out_ready = 1'b0; cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      cyc++;
      start = v.poke && (cyc == 4);
      base_addr = v.poke ? 8'h40 : v.base;
      out_ready = 1'b0;
      if (hold_on && !out_valid)
        check({tag, "_valid_held"}, 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (hold_on) begin
          check({tag, "_data_held"}, 32'(out_data), 32'(held));
        end else begin
          check({tag, "_lat"}, 32'(cyc),
                32'((n == 0) ? 3 : last_acc + 3));
          if (n < 32) check({tag, "_byte"}, 32'(out_data), 32'(v.exp[n]));
          else check({tag, "_overrun"}, 32'(n), 32'd31);
          held = out_data;
          hold_on = 1'b1;
        end
        if (n == v.stall_at && stalled < v.stall_len) begin
          stalled++;
        end else begin
          out_ready = 1'b1;
          hold_on = 1'b0;
          last_acc = cyc;
          n++;
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
    end
    exp_stall = (v.stall_at < v.len) ? v.stall_len : 0;
    check({tag, "_count"}, 32'(n), 32'(v.len));
    check({tag, "_dones"}, 32'(dones), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(3 * (v.len + 1) + exp_stall));
    xs = '0;
    for (int i = 0; i < v.len; i++) xs ^= v.exp[i];
`ifdef MSG_READER_CHECKSUM_EN
    check({tag, "_chk"}, 32'(chk), 32'(xs));
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
`ifdef MSG_READER_CHECKSUM_EN
    check({tag, "_chk_hold"}, 32'(chk), 32'(xs));
`else
    if (xs == 8'hFF) $display("note: %s xor ff", tag);
`endif
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) rom[i] = 8'h5A;
    rom[8'h10] = 8'h48; rom[8'h11] = 8'h49;
    rom[8'h12] = 8'h21; rom[8'h13] = 8'h00;
    rom[8'hFE] = 8'h41; rom[8'hFF] = 8'h42; rom[8'h00] = 8'h00;
    rom[8'h20] = 8'h00;
    for (int i = 0; i < 40; i++) rom[8'h40 + i] = 8'(8'h80 + i);

    for (int i = 0; i < 6; i++) begin
      vecs[i].stall_at = 99; vecs[i].stall_len = 0; vecs[i].poke = 0;
      for (int j = 0; j < 32; j++) vecs[i].exp[j] = 8'h00;
    end
    vecs[0].base = 8'h10; vecs[0].len = 3;
    vecs[0].exp[0] = 8'h48; vecs[0].exp[1] = 8'h49; vecs[0].exp[2] = 8'h21;
    vecs[1] = vecs[0]; vecs[1].stall_at = 1; vecs[1].stall_len = 5;
    vecs[2].base = 8'hFE; vecs[2].len = 2;
    vecs[2].exp[0] = 8'h41; vecs[2].exp[1] = 8'h42;
    vecs[3].base = 8'h40; vecs[3].len = 32;
    for (int j = 0; j < 32; j++) vecs[3].exp[j] = 8'(8'h80 + j);
    vecs[4].base = 8'h20; vecs[4].len = 0;
    vecs[5] = vecs[0]; vecs[5].poke = 1;
    vecs[5].stall_at = 0; vecs[5].stall_len = 2;

    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; out_ready = 1'b0;
    #12;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset mid-message while a byte is being presented.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h10; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("mid_reached_present", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    #3 rst_n = 1'b1;
    run(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
